// File: rtl/display_pkg.sv
// Shared types for the 7-segment display blocks: digit/frame types and slot state.
// Latency: none (types and one pure function only).
// Backpressure: n/a.
package display_pkg;

    localparam int N_DIGITS = 4;

    typedef logic [3:0]                digit_t;
    typedef logic [N_DIGITS-1:0][3:0]  digits_t;

    // BLANK: all anodes off (anti-ghosting window); SHOW: selected digit lit.
    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // One-hot-low anode pattern for a digit index.
    function automatic logic [N_DIGITS-1:0] anode_onehot_low(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/lz_blank.sv
// Leading-zero blank mask: bit n set means digit n must stay dark.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   digits   in  4 BCD digits, [3] is the most significant
//   blank_lz in  1 enables suppression; when 0 the mask is all zeros
//   mask     out 4 per-digit blank flags; digit 0 is never blanked
module lz_blank
    import display_pkg::*;
(
    input  digits_t                digits,
    input  logic                   blank_lz,
    output logic [N_DIGITS-1:0]    mask
);

    // Each digit is blank only if it and every more significant digit is zero,
    // so the chain propagates from the MSD downwards.
    always_comb begin
        mask    = '0;
        mask[3] = blank_lz && (digits[3] == 4'd0);
        mask[2] = mask[3]  && (digits[2] == 4'd0);
        mask[1] = mask[2]  && (digits[1] == 4'd0);
        mask[0] = 1'b0;
    end

endmodule

// File: rtl/display_scan_ctrl.sv
// 4-digit 7-segment scan controller with blanking window and frame-aligned double buffer.
// Latency: outputs are registered from next-state decode, so they match the current slot with no lag.
// Backpressure: load_ready drops after an accept and returns the cycle after the frame-boundary swap.
//
// Ports:
//   clk, rst_n    clock and synchronous active-low reset
//   load_data     in  4x4 BCD digits ([3] = MSD), load_valid/load_ready handshake
//   blank_lz      in  leading-zero suppression enable, sampled every cycle
//   digit_idx     out slot currently scanned
//   s_muxfue      out BCD value of the scanned digit, to the segment decoder
//   an_o          out active-low anode enables
//   frame_start   out one-cycle pulse on the first cycle of each frame
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 27000,
    parameter int BLANK_CYC   = 270
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0][3:0]  load_data,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             blank_lz,
    output logic [1:0]       digit_idx,
    output logic [3:0]       s_muxfue,
    output logic [3:0]       an_o,
    output logic             frame_start
);

    localparam int              CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYC);

    // Slot/frame position
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    // run_q is clear only for the cycle directly after reset; the first
    // non-reset edge reloads slot 0/cycle 0 so that cycle carries frame_start.
    logic             run_q, run_d;

    // Display and pending buffers
    digits_t          disp_q, disp_d;
    digits_t          pend_q, pend_d;
    logic             pend_v_q, pend_v_d;

    // Registered outputs
    logic [3:0]       an_q, an_d;
    logic [3:0]       smux_q, smux_d;
    logic [1:0]       didx_q, didx_d;
    logic             fs_q, fs_d;
    logic             rdy_q, rdy_d;

    logic             slot_end;
    logic             accept;
    logic             swap;
    scan_state_t      slot_state;
    logic [3:0]       blank_mask;

    // Mask is computed on the next-state display so a swap and its
    // blanking take effect in the same cycle.
    lz_blank u_lz_blank (
        .digits   (disp_d),
        .blank_lz (blank_lz),
        .mask     (blank_mask)
    );

    // Next-state: slot counter, digit index, buffers
    always_comb begin
        run_d    = 1'b1;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        disp_d   = disp_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;

        slot_end = run_q && (cnt_q == CNT_LAST);
        accept   = load_valid && rdy_q;
        // Only at the very last cycle of a frame, so a new value never tears.
        swap     = slot_end && (idx_q == 2'd3) && pend_v_q;

        if (!run_q) begin
            cnt_d = '0;
            idx_d = 2'd0;
        end else if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // accept needs pend_v=0 and swap needs pend_v=1: never both.
        if (swap) begin
            disp_d   = pend_q;
            pend_v_d = 1'b0;
        end
        if (accept) begin
            pend_d   = load_data;
            pend_v_d = 1'b1;
        end
    end

    // Output decode from next state
    always_comb begin
        slot_state = (cnt_d < CNT_SHOW) ? BLANK : SHOW;
        an_d       = 4'hF;
        if ((slot_state == SHOW) && !blank_mask[idx_d]) begin
            an_d = anode_onehot_low(idx_d);
        end
        // A blanked digit still drives its value to the decoder.
        smux_d = disp_d[idx_d];
        didx_d = idx_d;
        fs_d   = (cnt_d == '0) && (idx_d == 2'd0);
        rdy_d  = !pend_v_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            idx_q    <= 2'd0;
            run_q    <= 1'b0;
            disp_q   <= '0;
            pend_q   <= '0;
            pend_v_q <= 1'b0;
            an_q     <= 4'hF;
            smux_q   <= 4'd0;
            didx_q   <= 2'd0;
            fs_q     <= 1'b0;
            rdy_q    <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            run_q    <= run_d;
            disp_q   <= disp_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            an_q     <= an_d;
            smux_q   <= smux_d;
            didx_q   <= didx_d;
            fs_q     <= fs_d;
            rdy_q    <= rdy_d;
        end
    end

    assign load_ready  = rdy_q;
    assign digit_idx   = didx_q;
    assign s_muxfue    = smux_q;
    assign an_o        = an_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = 4 * RD;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [3:0][3:0]  load_data;
    logic             load_valid;
    logic             load_ready;
    logic             blank_lz;
    logic [1:0]       digit_idx;
    logic [3:0]       s_muxfue;
    logic [3:0]       an_o;
    logic             frame_start;

    display_scan_ctrl #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_data   (load_data),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .blank_lz    (blank_lz),
        .digit_idx   (digit_idx),
        .s_muxfue    (s_muxfue),
        .an_o        (an_o),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int pos    = 0;   // cycles since the first post-reset edge

    typedef struct packed {
        logic            lz;
        logic [3:0][3:0] dig;
        logic [3:0][3:0] an;   // expected SHOW-phase anodes per slot
        logic [3:0][3:0] s;    // expected s_muxfue per slot
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s pos=%0d got=%h want=%h", name, pos, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        pos++;
    endtask

    // One full frame (starting at a frame boundary) against expected anodes/digits.
    task automatic full_frame(input string name, input vec_t v);
        for (int c = 0; c < FRAME; c++) begin
            int cn;
            int ix;
            logic [3:0] ea;
            cn = pos % RD;
            ix = (pos / RD) % 4;
            ea = (cn < BC) ? 4'hF : v.an[ix];
            chk(name, {an_o, s_muxfue, 2'b00, digit_idx, 3'b000, frame_start},
                {ea, v.s[ix], 2'b00, 2'(ix), 3'b000, 1'(cn == 0 && ix == 0)});
            tick();
        end
    endtask

    // n cycles checking only the digit value and index.
    task automatic s_run(input string name, input logic [3:0][3:0] dig, input int n);
        for (int c = 0; c < n; c++) begin
            int ix;
            ix = (pos / RD) % 4;
            chk(name, {s_muxfue, 2'b00, digit_idx}, {dig[ix], 2'b00, 2'(ix)});
            tick();
        end
    endtask

    task automatic chk_reset_vals(input string name);
        chk(name, {an_o, s_muxfue, 2'b00, digit_idx, 3'b000, load_ready, 3'b000, frame_start},
            {4'hF, 4'h0, 2'b00, 2'd0, 3'b000, 1'b1, 3'b000, 1'b0});
    endtask

    initial begin
        #200000;
        $display("FAIL timeout pos=%0d", pos);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t prev;
        int   wn;

        vecs[0] = '{lz: 1'b0, dig: 16'h2605, an: 16'h7BDE, s: 16'h2605};
        vecs[1] = '{lz: 1'b1, dig: 16'h0040, an: 16'hFFDE, s: 16'h0040};
        vecs[2] = '{lz: 1'b1, dig: 16'h0000, an: 16'hFFFE, s: 16'h0000};
        vecs[3] = '{lz: 1'b0, dig: 16'h0000, an: 16'h7BDE, s: 16'h0000};
        vecs[4] = '{lz: 1'b1, dig: 16'h0105, an: 16'hFBDE, s: 16'h0105};
        vecs[5] = '{lz: 1'b1, dig: 16'h9000, an: 16'h7BDE, s: 16'h9000};

        rst_n      = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        blank_lz   = 1'b0;

        // Reset and idle
        for (int r = 0; r < 3; r++) begin
            tick();
            chk_reset_vals("reset_hold");
        end
        rst_n = 1'b1;
        tick();
        pos = 0;
        chk("fs_after_release", 32'(frame_start), 32'd1);
        prev = '{lz: 1'b0, dig: 16'h0000, an: 16'h7BDE, s: 16'h0000};
        full_frame("idle_frame", prev);

        // Table-driven loads, each loaded at a frame boundary
        for (int i = 0; i < 6; i++) begin
            chk("ready_before_load", 32'(load_ready), 32'd1);
            blank_lz   = vecs[i].lz;
            load_data  = vecs[i].dig;
            load_valid = 1'b1;
            tick();
            load_valid = 1'b0;
            load_data  = 16'hFFFF;
            // Old value must persist until the frame boundary
            while (pos % FRAME != 0) begin
                int ix;
                ix = (pos / RD) % 4;
                chk("hold_old_value", {s_muxfue, 2'b00, digit_idx, 3'b000, load_ready},
                    {prev.s[ix], 2'b00, 2'(ix), 3'b000, 1'b0});
                if (vecs[i].dig == prev.dig && vecs[i].lz == 1'b0) begin
                    int cn;
                    cn = pos % RD;
                    chk("lz_off_relit", 32'(an_o), 32'((cn < BC) ? 4'hF : vecs[i].an[ix]));
                end
                tick();
            end
            full_frame($sformatf("vec%0d", i), vecs[i]);
            prev = vecs[i];
        end

        // Backpressure: two values back to back
        blank_lz   = 1'b0;
        load_data  = 16'h1234;
        load_valid = 1'b1;
        tick();
        chk("bp_ready_low", 32'(load_ready), 32'd0);
        load_data = 16'h5678;
        wn = 0;
        while (!load_ready && wn < 40) begin
            tick();
            wn++;
        end
        chk("bp_ready_rise_at_boundary", 32'(pos % FRAME), 32'd0);
        chk("bp_first_shown", 32'(s_muxfue), 32'h4);
        tick();
        load_valid = 1'b0;
        chk("bp_second_pending", 32'(load_ready), 32'd0);
        s_run("bp_first_frame", 16'h1234, FRAME - 1);
        s_run("bp_second_frame", 16'h5678, FRAME);

        // Late accept at the last cycle of a frame
        while (pos % FRAME != FRAME - 1) tick();
        chk("late_ready", 32'(load_ready), 32'd1);
        load_data  = 16'h0987;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        chk("late_accepted", 32'(load_ready), 32'd0);
        s_run("late_not_next_frame", 16'h5678, FRAME);
        s_run("late_shown", 16'h0987, FRAME);

        // Reset mid-frame with pending data
        load_data  = 16'h7777;
        load_valid = 1'b1;
        tick();
        load_valid = 1'b0;
        while (pos % FRAME != 2 * RD + 4) tick();
        chk("mid_pending", {load_ready, 2'b00, digit_idx}, {1'b0, 2'b00, 2'd2});
        rst_n = 1'b0;
        tick();
        chk_reset_vals("mid_reset_vals");
        rst_n = 1'b1;
        tick();
        pos = 0;
        chk("fs_after_mid_release", 32'(frame_start), 32'd1);
        s_run("pending_lost", 16'h0000, 2 * FRAME + 1);
        chk("ready_after_mid_reset", 32'(load_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
